tx_channel_arbiter: RTL and testbench
=====================================

Name: tx_channel_arbiter

Overview:
- Native, parametrised N-input packet arbiter that merges per-source transaction-layer channels onto the single tx stream.
- Sources include aw, ar, r, b and barrier, plus channels added later.
- Replaces the vendor stream-switch instance in the tx path.
- Adds:
  - packet-atomic grant locking,
  - a priority channel with bounded consecutive wins (starvation guard),
  - per-channel enable,
  - a registered output stage.

Parameters:
- DATA_WIDTH, 16, data bus width in bytes.
- NUM_CH, 5, number of input channels (2..16).
- PRIO_CH, 0, index of the priority channel (the barrier channel in the tx path).
- PRIO_MAX, 4, maximum consecutive priority-rule grants before one round-robin grant is forced (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  NUM_CH  per-channel valid.
- s_ready  out  NUM_CH  per-channel ready.
- s_data  in  NUM_CH*DATA_WIDTH*8  channel i at [i*DATA_WIDTH*8 +: DATA_WIDTH*8].
- s_keep  in  NUM_CH*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_last  in  NUM_CH  per-channel end of packet.
- s_connection_id  in  NUM_CH*4  channel i at [i*4 +: 4].
- s_byte_num  in  NUM_CH*13  channel i at [i*13 +: 13].
- ch_enable  in  NUM_CH  1 = channel may win new arbitration.
- tx_data  out  DATA_WIDTH*8  merged data.
- tx_keep  out  DATA_WIDTH  merged keep.
- tx_connection_id  out  4  connection id of current packet.
- tx_byte_num  out  13  byte count of current packet.
- tx_last  out  1  end of packet.
- tx_valid  out  1  output valid.
- tx_ready  in  1  downstream ready.
- grant_idx  out  GW  currently locked channel, where GW = max(1,$clog2(NUM_CH)).
- busy  out  1  high while a packet is locked (state XFER).

Behaviour:
- Reset (asynchronous, active-high). All of the following clear immediately:
  - tx_valid=0, tx_last=0, tx_data=0, tx_keep=0, tx_connection_id=0, tx_byte_num=0.
  - s_ready=0, grant_idx=0, busy=0.
  - state=IDLE, rr_ptr=NUM_CH-1 (so channel 0 wins first round-robin), prio_cnt=0.
- Reset mid-packet: the packet is dropped, with no partial-packet recovery. Upstream sources are reset on the same reset.
- Eligibility: eligible[i] = s_valid[i] & ch_enable[i].
- FSM state IDLE:
  - s_ready=0.
  - If any channel is eligible, the grant is computed and registered, and the FSM moves to XFER on the next edge.
  - Otherwise the FSM stays in IDLE.
- Grant rule, evaluated only in IDLE:
  1. If eligible[PRIO_CH] and prio_cnt<PRIO_MAX: grant PRIO_CH, and prio_cnt increments (saturating at PRIO_MAX).
  2. Otherwise, round-robin over all eligible channels (PRIO_CH included), searching from rr_ptr+1 with wrap at NUM_CH-1 -> 0.
     - rr_ptr is set to the winner.
     - prio_cnt clears to 0 if the winner is not PRIO_CH.
     - If the only eligible channel is PRIO_CH, it is granted and prio_cnt stays saturated.
- FSM state XFER:
  - s_ready[grant_idx] = ~tx_valid | tx_ready. All other s_ready bits are 0.
  - On s_valid[g] & s_ready[g], the output register loads data, keep, last, connection_id and byte_num from channel g, and tx_valid is set to 1.
  - If tx_ready & tx_valid and no new load occurs, tx_valid clears to 0.
  - When the accepted beat has s_last=1, the FSM returns to IDLE on the next edge.
- Throughput and latency:
  - Sustains one beat per clock within a packet.
  - Input-to-tx_valid latency is 1 cycle.
  - At most one IDLE bubble cycle between packets; a new grant may be made while the last beat still sits in the output register.
  - The combinational path tx_ready -> s_ready is allowed.
- Atomicity: the grant is held until the s_last beat is accepted.
  - Deasserting ch_enable or s_valid mid-packet does not release the grant; the FSM waits in XFER.
  - tx_connection_id and tx_byte_num are carried per beat unchanged.
- Output hold: while tx_valid=1 and tx_ready=0, all tx_* outputs are stable.
- Single-beat packet: s_last on the first beat is legal; IDLE -> XFER -> IDLE.
- No enabled channels: remain in IDLE indefinitely, with no output.

Decomposition:
- Package tx_arb_pkg holds:
  - CONN_ID_W=4, BYTE_NUM_W=13,
  - the state enum {IDLE, XFER},
  - the clog2-with-minimum-1 helper function.
- Sub-module tx_rr_arbiter: purely combinational.
  - Inputs: eligible, rr_ptr, prio_cnt, PRIO_CH, PRIO_MAX.
  - Outputs: grant one-hot, grant index, prio_win flag.
- The top level contains the FSM, rr_ptr/prio_cnt registers, the input mux and the output register.

Test Plan:
- Reset, then channel 2 sends a 3-beat packet (byte_num=40, conn=5) with tx_ready=1 -> tx_valid first asserts 1 cycle after the first s_valid; 3 beats with tx_last on beat 3; tx_connection_id=5, tx_byte_num=40; grant_idx=2.
- Channels 1, 3, 4 hold single-beat packets continuously; PRIO_CH=0 idle -> grant order 1, 3, 4, 1, 3, 4; no channel is granted twice in a row.
- PRIO_MAX=4, channel 0 and channel 3 always valid -> grants 0, 0, 0, 0, 3, 0, 0, 0, 0, 3.
- Channel 1 mid-packet (beat 2 of 4) while channel 0 asserts valid -> channel 1 completes all 4 beats before channel 0 is granted; no interleaving on tx.
- tx_ready toggles 1, 0, 0, 1 during a 4-beat packet -> tx_* stable while stalled; s_ready[g]=0 while tx_valid & ~tx_ready; all 4 beats delivered in order.
- Assert reset while in XFER beat 2 -> tx_valid, s_ready and busy read 0 immediately; the next packet after release is granted to channel 0 first by round-robin.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared widths, FSM states and helpers for the tx channel arbiter
package tx_arb_pkg;

    localparam int CONN_ID_W  = 4;
    localparam int BYTE_NUM_W = 13;
    localparam int PRIO_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// rtl/tx_rr_arbiter.sv - combinational priority/round-robin grant selection
module tx_rr_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int PRIO_CH  = 0,
    parameter int PRIO_MAX = 4,
    parameter int GW       = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0]     eligible,
    input  logic [GW-1:0]         rr_ptr,
    input  logic [PRIO_CNT_W-1:0] prio_cnt,
    output logic [NUM_CH-1:0]     grant,
    output logic [GW-1:0]         grant_idx,
    output logic                  prio_win
);

    localparam logic [GW-1:0]         PRIO_IDX     = GW'(PRIO_CH);
    localparam logic [PRIO_CNT_W-1:0] PRIO_CNT_MAX = PRIO_CNT_W'(PRIO_MAX);

    logic found;
    int   cand;

    // Priority channel wins while under its consecutive-win budget; otherwise
    // search forward from the channel after rr_ptr, wrapping at NUM_CH-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        prio_win  = 1'b0;
        found     = 1'b0;
        cand      = 0;
        if (eligible[PRIO_CH] && (prio_cnt < PRIO_CNT_MAX)) begin
            prio_win  = 1'b1;
            grant_idx = PRIO_IDX;
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end
                if (!found && eligible[cand]) begin
                    found     = 1'b1;
                    grant_idx = GW'(cand);
                end
            end
        end
        if (prio_win || found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tx_channel_arbiter.sv
// rtl/tx_channel_arbiter.sv - packet-atomic N-input arbiter onto the tx stream
module tx_channel_arbiter
    import tx_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_CH     = 5,
    parameter  int PRIO_CH    = 0,
    parameter  int PRIO_MAX   = 4,
    localparam int GW         = clog2_min1(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              s_valid,
    output logic [NUM_CH-1:0]              s_ready,
    input  logic [NUM_CH*DATA_WIDTH*8-1:0] s_data,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_keep,
    input  logic [NUM_CH-1:0]              s_last,
    input  logic [NUM_CH*CONN_ID_W-1:0]    s_connection_id,
    input  logic [NUM_CH*BYTE_NUM_W-1:0]   s_byte_num,
    input  logic [NUM_CH-1:0]              ch_enable,
    output logic [DATA_WIDTH*8-1:0]        tx_data,
    output logic [DATA_WIDTH-1:0]          tx_keep,
    output logic [CONN_ID_W-1:0]           tx_connection_id,
    output logic [BYTE_NUM_W-1:0]          tx_byte_num,
    output logic                           tx_last,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [GW-1:0]                  grant_idx,
    output logic                           busy
);

    localparam int                    DB           = DATA_WIDTH * 8;
    localparam logic [GW-1:0]         PRIO_IDX     = GW'(PRIO_CH);
    localparam logic [PRIO_CNT_W-1:0] PRIO_CNT_MAX = PRIO_CNT_W'(PRIO_MAX);

    state_t                  state;
    state_t                  state_nxt;
    logic [GW-1:0]           rr_ptr;
    logic [PRIO_CNT_W-1:0]   prio_cnt;
    logic [PRIO_CNT_W-1:0]   prio_cnt_nxt;
    logic [NUM_CH-1:0]       eligible;
    logic [NUM_CH-1:0]       arb_grant;
    logic [GW-1:0]           arb_idx;
    logic                    arb_prio_win;
    logic                    grant_take;
    logic                    load;
    logic                    out_free;

    logic                    sel_valid;
    logic [DB-1:0]           sel_data;
    logic [DATA_WIDTH-1:0]   sel_keep;
    logic                    sel_last;
    logic [CONN_ID_W-1:0]    sel_conn;
    logic [BYTE_NUM_W-1:0]   sel_bnum;

    assign eligible   = s_valid & ch_enable;
    assign busy       = (state == XFER);
    assign out_free   = ~tx_valid | tx_ready;
    assign grant_take = (state == IDLE) && (|arb_grant);

    tx_rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .PRIO_CH  (PRIO_CH),
        .PRIO_MAX (PRIO_MAX),
        .GW       (GW)
    ) u_rr_arbiter (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .prio_cnt  (prio_cnt),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .prio_win  (arb_prio_win)
    );

    // Priority-win budget: count priority-rule wins, hold when the priority
    // channel wins by round-robin (it was alone), clear on any other winner.
    always_comb begin
        prio_cnt_nxt = '0;
        if (arb_prio_win) begin
            prio_cnt_nxt = (prio_cnt < PRIO_CNT_MAX) ? prio_cnt + 1'b1 : prio_cnt;
        end else if (arb_idx == PRIO_IDX) begin
            prio_cnt_nxt = prio_cnt;
        end
    end

    // Select the locked channel's beat fields.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_conn  = '0;
        sel_bnum  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_valid = s_valid[i];
                sel_data  = s_data[i*DB +: DB];
                sel_keep  = s_keep[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last  = s_last[i];
                sel_conn  = s_connection_id[i*CONN_ID_W +: CONN_ID_W];
                sel_bnum  = s_byte_num[i*BYTE_NUM_W +: BYTE_NUM_W];
            end
        end
    end

    // FSM next state and per-channel ready; only the locked channel is ever ready.
    always_comb begin
        state_nxt = state;
        s_ready   = '0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (|arb_grant) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                s_ready[grant_idx] = out_free;
                load               = sel_valid & out_free;
                if (load && sel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, lock and arbitration history. rr_ptr follows every winner, so a
    // forced round-robin turn after a priority streak starts past PRIO_CH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= GW'(NUM_CH - 1);
            prio_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_take) begin
                grant_idx <= arb_idx;
                rr_ptr    <= arb_idx;
                prio_cnt  <= prio_cnt_nxt;
            end
        end
    end

    // Output register: load on handshake, drop valid once consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid         <= 1'b0;
            tx_last          <= 1'b0;
            tx_data          <= '0;
            tx_keep          <= '0;
            tx_connection_id <= '0;
            tx_byte_num      <= '0;
        end else if (load) begin
            tx_valid         <= 1'b1;
            tx_last          <= sel_last;
            tx_data          <= sel_data;
            tx_keep          <= sel_keep;
            tx_connection_id <= sel_conn;
            tx_byte_num      <= sel_bnum;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// tb/tb_tx_channel_arbiter.sv - self-checking bench for tx_channel_arbiter
module tb_tx_channel_arbiter;

    localparam int DW   = 4;
    localparam int NCH  = 5;
    localparam int PCH  = 0;
    localparam int PMAX = 4;
    localparam int GW   = 3;
    localparam int DB   = DW * 8;

    typedef struct packed {
        logic [DB-1:0] data;
        logic [DW-1:0] keep;
        logic          last;
        logic [3:0]    conn;
        logic [12:0]   bnum;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       s_valid;
    logic [NCH-1:0]       s_ready;
    logic [NCH*DB-1:0]    s_data;
    logic [NCH*DW-1:0]    s_keep;
    logic [NCH-1:0]       s_last;
    logic [NCH*4-1:0]     s_connection_id;
    logic [NCH*13-1:0]    s_byte_num;
    logic [NCH-1:0]       ch_enable;
    logic [DB-1:0]        tx_data;
    logic [DW-1:0]        tx_keep;
    logic [3:0]           tx_connection_id;
    logic [12:0]          tx_byte_num;
    logic                 tx_last;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [GW-1:0]        grant_idx;
    logic                 busy;

    always #5 clk = ~clk;

    tx_channel_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .PRIO_CH    (PCH),
        .PRIO_MAX   (PMAX)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_keep           (s_keep),
        .s_last           (s_last),
        .s_connection_id  (s_connection_id),
        .s_byte_num       (s_byte_num),
        .ch_enable        (ch_enable),
        .tx_data          (tx_data),
        .tx_keep          (tx_keep),
        .tx_connection_id (tx_connection_id),
        .tx_byte_num      (tx_byte_num),
        .tx_last          (tx_last),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .grant_idx        (grant_idx),
        .busy             (busy)
    );

    beat_t src_q[NCH][$];
    beat_t exp_q[$];
    int    grant_log[$];
    int    exp_grants[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    int    tx_beats = 0;
    int    first_hs = -1;
    int    first_txv = -1;
    int    m_ptr;
    int    m_cnt;
    logic  prev_busy;
    logic  prev_stall;
    beat_t prev_out;

    function automatic beat_t out_beat();
        beat_t b;
        b.data = tx_data;
        b.keep = tx_keep;
        b.last = tx_last;
        b.conn = tx_connection_id;
        b.bnum = tx_byte_num;
        return b;
    endfunction

    task automatic drive_inputs();
        beat_t b;
        for (int i = 0; i < NCH; i++) begin
            b = '0;
            if (src_q[i].size() > 0) b = src_q[i][0];
            s_valid[i]                = (src_q[i].size() > 0);
            s_data[i*DB +: DB]        = b.data;
            s_keep[i*DW +: DW]        = b.keep;
            s_last[i]                 = b.last;
            s_connection_id[i*4 +: 4] = b.conn;
            s_byte_num[i*13 +: 13]    = b.bnum;
        end
    endtask

    task automatic add_packet(input int ch, input int len, input int conn, input int bnum);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = DB'($urandom);
            b.keep = DW'($urandom);
            b.last = (k == len - 1);
            b.conn = 4'(conn);
            b.bnum = 13'(bnum);
            src_q[ch].push_back(b);
        end
    endtask

    // Reference arbitration: all queued packets are present up front, so at
    // each decision the eligible set is simply the enabled non-empty queues.
    task automatic model_run(input logic [NCH-1:0] en);
        beat_t mq[NCH][$];
        int    w;
        bit    any;
        for (int i = 0; i < NCH; i++) mq[i] = src_q[i];
        forever begin
            any = 0;
            for (int i = 0; i < NCH; i++) if (en[i] && mq[i].size() > 0) any = 1;
            if (!any) break;
            w = -1;
            if (en[PCH] && mq[PCH].size() > 0 && m_cnt < PMAX) begin
                w = PCH;
            end else begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_ptr + k) % NCH;
                    if (w < 0 && en[c] && mq[c].size() > 0) w = c;
                end
            end
            m_ptr = w;
            m_cnt = (w == PCH) ? ((m_cnt < PMAX) ? m_cnt + 1 : PMAX) : 0;
            exp_grants.push_back(w);
            forever begin
                beat_t b;
                b = mq[w].pop_front();
                exp_q.push_back(b);
                if (b.last) break;
            end
        end
    endtask

    task automatic step();
        logic [NCH-1:0] hs;
        beat_t          got;
        beat_t          exp;
        @(negedge clk);
        hs = s_valid & s_ready;
        if (hs != '0 && first_hs < 0) first_hs = cyc;
        if (tx_valid && first_txv < 0) first_txv = cyc;
        if (busy && !prev_busy) grant_log.push_back(int'(grant_idx));
        if (prev_stall) begin
            checks++;
            if (out_beat() !== prev_out || tx_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable: got %0h valid %0b, expected %0h valid 1", out_beat(), tx_valid, prev_out);
            end
        end
        if (tx_valid && !tx_ready) begin
            checks++;
            if (s_ready !== '0) begin
                errors++;
                $display("FAIL stall_ready: got s_ready %0b, expected 0", s_ready);
            end
        end
        if (tx_valid && tx_ready) begin
            tx_beats++;
            got = out_beat();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_beat: got unexpected beat %0h, expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL tx_beat: got %0h, expected %0h", got, exp);
                end
            end
        end
        prev_busy  = busy;
        prev_stall = tx_valid & ~tx_ready;
        prev_out   = out_beat();
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) if (hs[i]) void'(src_q[i].pop_front());
        cyc++;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
        drive_inputs();
    endtask

    task automatic run_until(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_grants(input string name);
        bit bad;
        bad = (grant_log.size() != exp_grants.size());
        for (int i = 0; i < grant_log.size() && !bad; i++) bad = (grant_log[i] != exp_grants[i]);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s_grants: got %p, expected %p", name, grant_log, exp_grants);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rdy_mode  = 0;
        tx_ready  = 1'b1;
        ch_enable = '1;
        for (int i = 0; i < NCH; i++) src_q[i].delete();
        exp_q.delete();
        grant_log.delete();
        exp_grants.delete();
        drive_inputs();
        m_ptr      = NCH - 1;
        m_cnt      = 0;
        prev_busy  = 1'b0;
        prev_stall = 1'b0;
        first_hs   = -1;
        first_txv  = -1;
        tx_beats   = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({tx_valid, tx_last, tx_data, tx_keep, tx_connection_id, tx_byte_num} !== '0) begin
            errors++;
            $display("FAIL reset_tx: got %0h, expected 0", {tx_valid, tx_last, tx_data, tx_keep, tx_connection_id, tx_byte_num});
        end
        checks++;
        if (s_ready !== '0) begin
            errors++;
            $display("FAIL reset_s_ready: got %0b, expected 0", s_ready);
        end
        checks++;
        if ({grant_idx, busy} !== '0) begin
            errors++;
            $display("FAIL reset_grant_busy: got %0h, expected 0", {grant_idx, busy});
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_packet();
        do_reset();
        add_packet(2, 3, 5, 40);
        model_run(ch_enable);
        drive_inputs();
        run_until(50, "single");
        checks++;
        if (first_txv != first_hs + 1) begin
            errors++;
            $display("FAIL single_latency: got tx_valid at %0d, expected %0d", first_txv, first_hs + 1);
        end
        checks++;
        if (tx_beats != 3) begin
            errors++;
            $display("FAIL single_beats: got %0d, expected 3", tx_beats);
        end
        checks++;
        if (grant_log.size() != 1 || grant_log[0] != 2) begin
            errors++;
            $display("FAIL single_grant: got %p, expected 2", grant_log);
        end
    endtask

    task automatic test_round_robin();
        int want[6];
        want = '{1, 3, 4, 1, 3, 4};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            add_packet(1, 1, 1, 11);
            add_packet(3, 1, 3, 33);
            add_packet(4, 1, 4, 44);
        end
        model_run(ch_enable);
        drive_inputs();
        run_until(200, "rr");
        check_grants("rr");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= grant_log.size() || grant_log[i] != want[i]) begin
                errors++;
                $display("FAIL rr_order_%0d: got %p, expected %0d", i, grant_log, want[i]);
            end
        end
    endtask

    task automatic test_prio_guard();
        int want[10];
        bit bad;
        want = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
        do_reset();
        for (int r = 0; r < 8; r++) add_packet(0, 1, 0, r);
        for (int r = 0; r < 2; r++) add_packet(3, 1, 3, 100 + r);
        model_run(ch_enable);
        drive_inputs();
        run_until(200, "prio");
        check_grants("prio");
        bad = (grant_log.size() != 10);
        for (int i = 0; i < 10 && !bad; i++) bad = (grant_log[i] != want[i]);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL prio_order: got %p, expected %p", grant_log, want);
        end
    endtask

    task automatic test_atomic();
        int n;
        do_reset();
        add_packet(1, 4, 2, 64);
        model_run(ch_enable);
        drive_inputs();
        n = 0;
        while (tx_beats < 2 && n < 50) begin
            step();
            n++;
        end
        add_packet(0, 2, 9, 8);
        foreach (src_q[0][k]) exp_q.push_back(src_q[0][k]);
        exp_grants.push_back(0);
        drive_inputs();
        run_until(100, "atomic");
        check_grants("atomic");
    endtask

    task automatic test_backpressure();
        do_reset();
        add_packet(3, 4, 7, 256);
        model_run(ch_enable);
        rdy_mode = 2;
        drive_inputs();
        run_until(100, "bp");
        check_grants("bp");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            ch_enable = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_packet(c, $urandom_range(1, 4), $urandom, $urandom);
            end
            model_run(ch_enable);
            rdy_mode = 1;
            drive_inputs();
            run_until(2000, "rand");
            check_grants("rand");
        end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        do_reset();
        add_packet(2, 4, 1, 80);
        model_run(ch_enable);
        drive_inputs();
        n = 0;
        while (tx_beats < 2 && n < 50) begin
            step();
            n++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tx_valid, s_ready, busy} !== '0) begin
            errors++;
            $display("FAIL midreset: got valid %0b ready %0b busy %0b, expected 0", tx_valid, s_ready, busy);
        end
        do_reset();
        for (int c = 0; c < NCH; c++) add_packet(c, 1, c, c);
        model_run(ch_enable);
        drive_inputs();
        run_until(200, "midreset");
        check_grants("midreset");
        checks++;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL midreset_first: got %p, expected first 0", grant_log);
        end
    endtask

    task automatic test_no_enabled();
        int bad;
        do_reset();
        ch_enable = '0;
        for (int c = 0; c < NCH; c++) add_packet(c, 2, c, c);
        drive_inputs();
        bad = 0;
        repeat (20) begin
            step();
            if (tx_valid || busy || s_ready != '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_enabled: got %0d active cycles, expected 0", bad);
        end
    endtask

    initial begin
        reset     = 1'b1;
        tx_ready  = 1'b1;
        ch_enable = '1;
        s_valid   = '0;
        s_data    = '0;
        s_keep    = '0;
        s_last    = '0;
        s_connection_id = '0;
        s_byte_num      = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_prio_guard();
        test_atomic();
        test_backpressure();
        test_random();
        test_reset_mid_packet();
        test_no_enabled();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
